// File: rtl/clock_pkg.sv
// Shared definitions for the clock datapath: BCD helpers, standard field
// moduli and the per-cycle operation selected by a counter stage.
package clock_pkg;

   localparam int SEC_MOD        = 60;
   localparam int MIN_MOD        = 60;
   localparam int HOUR24_MOD     = 24;
   localparam int HOUR12_MOD     = 12;
   localparam int HOUR12_MIN_VAL = 1;

   typedef enum logic [1:0] {
      OP_HOLD,
      OP_LOAD,
      OP_INC,
      OP_DEC
   } count_op_t;

   // Returns {tens, ones}; intended for constants in 0..99.
   function automatic logic [7:0] to_bcd(input int unsigned value);
      logic [3:0] tens;
      logic [3:0] ones;
      tens = 4'(value / 10);
      ones = 4'(value % 10);
      return {tens, ones};
   endfunction

   function automatic logic bcd_valid(input logic [3:0] tens, input logic [3:0] ones);
      return (tens <= 4'd9) && (ones <= 4'd9);
   endfunction

endpackage

// File: rtl/bcd_mod_counter_rise_detect.sv
// Single-bit rising-edge detector with a configurable reset value for the
// delayed sample, so a level already high at reset release is not seen as an edge.
module rise_detect #(
   parameter logic RESET_Q = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic sig,
   output logic rise
);

   logic sig_q;

   always_ff @(posedge clk) begin
      if (!reset) sig_q <= RESET_Q;
      else        sig_q <= sig;
   end

   assign rise = sig & ~sig_q;

endmodule

// File: rtl/bcd_mod_counter.sv
// Parametrised BCD modulo counter for one time field, chained via carry/borrow
// pulses; the BCD digits are tracked alongside the binary count to avoid a divider.
module bcd_mod_counter
   import clock_pkg::*;
#(
   parameter int MODULUS     = 60,
   parameter int MIN_VALUE   = 0,
   parameter int RESET_VALUE = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       inc,
   input  logic       dec,
   input  logic       load,
   input  logic [3:0] load_tens,
   input  logic [3:0] load_ones,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       carry_out,
   output logic       borrow_out,
   output logic       load_err
);

   localparam int MAX_VALUE = MIN_VALUE + MODULUS - 1;
   localparam int CW        = $clog2(MAX_VALUE + 1);

   localparam logic [CW-1:0] MIN_CNT   = CW'(MIN_VALUE);
   localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_VALUE);
   localparam logic [CW-1:0] RESET_CNT = CW'(RESET_VALUE);
   localparam logic [7:0]    MIN_BCD   = to_bcd(MIN_VALUE);
   localparam logic [7:0]    MAX_BCD   = to_bcd(MAX_VALUE);
   localparam logic [7:0]    RESET_BCD = to_bcd(RESET_VALUE);

   if (MODULUS < 2 || MODULUS > 99) begin : g_bad_modulus
      $error("bcd_mod_counter: MODULUS must be in 2..99");
   end
   if (MIN_VALUE < 0 || MAX_VALUE > 99) begin : g_bad_range
      $error("bcd_mod_counter: MIN_VALUE + MODULUS - 1 must not exceed 99");
   end
   if (RESET_VALUE < MIN_VALUE || RESET_VALUE > MAX_VALUE) begin : g_bad_reset
      $error("bcd_mod_counter: RESET_VALUE outside counting range");
   end

   logic            inc_re;
   logic            dec_re;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_next;
   logic [3:0]      tens_next;
   logic [3:0]      ones_next;
   logic            carry_next;
   logic            borrow_next;
   logic            err_next;
   logic [7:0]      load_val;
   logic            load_ok;
   count_op_t       op;

   rise_detect #(.RESET_Q(1'b1)) u_inc_rise (
      .clk   (clk),
      .reset (reset),
      .sig   (inc),
      .rise  (inc_re)
   );

   rise_detect #(.RESET_Q(1'b1)) u_dec_rise (
      .clk   (clk),
      .reset (reset),
      .sig   (dec),
      .rise  (dec_re)
   );

   // Out-of-range loads below MIN_VALUE wrap to a large offset, so one compare covers both bounds.
   always_comb begin
      load_val = 8'(load_tens) * 8'd10 + 8'(load_ones);
      load_ok  = bcd_valid(load_tens, load_ones) &&
                 ((load_val - 8'(MIN_VALUE)) < 8'(MODULUS));
   end

   always_comb begin
      op = OP_HOLD;
      if (load)                 op = OP_LOAD;
      else if (inc_re ^ dec_re) op = inc_re ? OP_INC : OP_DEC;
   end

   always_comb begin
      cnt_next    = cnt;
      tens_next   = tens;
      ones_next   = ones;
      carry_next  = 1'b0;
      borrow_next = 1'b0;
      err_next    = 1'b0;
      unique case (op)
         OP_LOAD: begin
            if (load_ok) begin
               cnt_next  = load_val[CW-1:0];
               tens_next = load_tens;
               ones_next = load_ones;
            end else begin
               err_next = 1'b1;
            end
         end
         OP_INC: begin
            if (cnt == MAX_CNT) begin
               cnt_next               = MIN_CNT;
               {tens_next, ones_next} = MIN_BCD;
               carry_next             = 1'b1;
            end else begin
               cnt_next = cnt + CW'(1);
               if (ones == 4'd9) begin
                  ones_next = 4'd0;
                  tens_next = tens + 4'd1;
               end else begin
                  ones_next = ones + 4'd1;
               end
            end
         end
         OP_DEC: begin
            if (cnt == MIN_CNT) begin
               cnt_next               = MAX_CNT;
               {tens_next, ones_next} = MAX_BCD;
               borrow_next            = 1'b1;
            end else begin
               cnt_next = cnt - CW'(1);
               if (ones == 4'd0) begin
                  ones_next = 4'd9;
                  tens_next = tens - 4'd1;
               end else begin
                  ones_next = ones - 4'd1;
               end
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt          <= RESET_CNT;
         {tens, ones} <= RESET_BCD;
         carry_out    <= 1'b0;
         borrow_out   <= 1'b0;
         load_err     <= 1'b0;
      end else begin
         cnt          <= cnt_next;
         tens         <= tens_next;
         ones         <= ones_next;
         carry_out    <= carry_next;
         borrow_out   <= borrow_next;
         load_err     <= err_next;
      end
   end

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Bench for bcd_mod_counter: a 00..59 and a 1..12 instance share stimulus and
// are compared each cycle against an arithmetic model; a 60/60/24 chain checks ripple.
module tb_bcd_mod_counter;

   typedef struct {
      int val;
      bit pi;
      bit pd;
      bit carry;
      bit borrow;
      bit err;
   } mstate_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       inc;
   logic       dec;
   logic       load;
   logic [3:0] load_tens;
   logic [3:0] load_ones;
   logic       c_inc;
   logic       c_load;

   logic [3:0] t60, o60, t12, o12;
   logic       c60, b60, e60, c12, b12, e12;
   logic [3:0] st, so, mt, mo, ht, ho;
   logic       s_carry, s_borrow, s_err, m_carry, m_borrow, m_err, h_carry, h_borrow, h_err;

   int      checks = 0;
   int      failures = 0;
   bit      check_en = 0;
   mstate_t m60;
   mstate_t m12;

   always #5 clk = ~clk;

   bcd_mod_counter #(.MODULUS(60), .MIN_VALUE(0), .RESET_VALUE(0)) dut60 (
      .clk(clk), .reset(reset), .inc(inc), .dec(dec), .load(load),
      .load_tens(load_tens), .load_ones(load_ones), .tens(t60), .ones(o60),
      .carry_out(c60), .borrow_out(b60), .load_err(e60)
   );

   bcd_mod_counter #(.MODULUS(12), .MIN_VALUE(1), .RESET_VALUE(12)) dut12 (
      .clk(clk), .reset(reset), .inc(inc), .dec(dec), .load(load),
      .load_tens(load_tens), .load_ones(load_ones), .tens(t12), .ones(o12),
      .carry_out(c12), .borrow_out(b12), .load_err(e12)
   );

   bcd_mod_counter #(.MODULUS(60), .MIN_VALUE(0), .RESET_VALUE(0)) u_sec (
      .clk(clk), .reset(reset), .inc(c_inc), .dec(1'b0), .load(c_load),
      .load_tens(4'd5), .load_ones(4'd9), .tens(st), .ones(so),
      .carry_out(s_carry), .borrow_out(s_borrow), .load_err(s_err)
   );

   bcd_mod_counter #(.MODULUS(60), .MIN_VALUE(0), .RESET_VALUE(0)) u_min (
      .clk(clk), .reset(reset), .inc(s_carry), .dec(s_borrow), .load(c_load),
      .load_tens(4'd5), .load_ones(4'd9), .tens(mt), .ones(mo),
      .carry_out(m_carry), .borrow_out(m_borrow), .load_err(m_err)
   );

   bcd_mod_counter #(.MODULUS(24), .MIN_VALUE(0), .RESET_VALUE(0)) u_hour (
      .clk(clk), .reset(reset), .inc(m_carry), .dec(m_borrow), .load(c_load),
      .load_tens(4'd2), .load_ones(4'd3), .tens(ht), .ones(ho),
      .carry_out(h_carry), .borrow_out(h_borrow), .load_err(h_err)
   );

   // Reference: value kept as a plain integer and stepped with modular arithmetic.
   function automatic mstate_t model_next(mstate_t s, int modv, int minv, int rstv,
                                          bit rst_n, bit i, bit d, bit l, int lt, int lo);
      mstate_t n;
      bit      ir, dr;
      int      off, lv;
      n = s;
      n.carry = 0;
      n.borrow = 0;
      n.err = 0;
      if (!rst_n) begin
         n.val = rstv;
         n.pi = 1;
         n.pd = 1;
         return n;
      end
      ir = i && !s.pi;
      dr = d && !s.pd;
      n.pi = i;
      n.pd = d;
      lv = lt * 10 + lo;
      if (l) begin
         if (lt <= 9 && lo <= 9 && lv >= minv && lv <= minv + modv - 1) n.val = lv;
         else n.err = 1;
      end else if (ir && !dr) begin
         off = s.val - minv + 1;
         n.carry = (off == modv);
         n.val = minv + off % modv;
      end else if (dr && !ir) begin
         off = s.val - minv - 1;
         n.borrow = (off < 0);
         n.val = minv + (off + modv) % modv;
      end
      return n;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input bit r, input bit i, input bit d, input bit l,
                                input int lt, input int lo);
      @(negedge clk);
      reset = r;
      inc = i;
      dec = d;
      load = l;
      load_tens = 4'(lt);
      load_ones = 4'(lo);
      @(posedge clk);
      m60 = model_next(m60, 60, 0, 0, r, i, d, l, lt, lo);
      m12 = model_next(m12, 12, 1, 12, r, i, d, l, lt, lo);
      #1;
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         checkOutput("tens60",   int'(t60), m60.val / 10);
         checkOutput("ones60",   int'(o60), m60.val % 10);
         checkOutput("carry60",  int'(c60), int'(m60.carry));
         checkOutput("borrow60", int'(b60), int'(m60.borrow));
         checkOutput("err60",    int'(e60), int'(m60.err));
         checkOutput("tens12",   int'(t12), m12.val / 10);
         checkOutput("ones12",   int'(o12), m12.val % 10);
         checkOutput("carry12",  int'(c12), int'(m12.carry));
         checkOutput("borrow12", int'(b12), int'(m12.borrow));
         checkOutput("err12",    int'(e12), int'(m12.err));
      end
   end

   function automatic int v60();
      return int'(t60) * 10 + int'(o60);
   endfunction

   function automatic int v12();
      return int'(t12) * 10 + int'(o12);
   endfunction

   initial begin
      int carries;
      reset = 1'b0;
      inc = 1'b0;
      dec = 1'b0;
      load = 1'b0;
      load_tens = 4'd0;
      load_ones = 4'd0;
      c_inc = 1'b0;
      c_load = 1'b0;
      m60 = '{default: 0};
      m12 = '{default: 0};

      applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      check_en = 1;
      checkOutput("reset_val60", v60(), 0);
      checkOutput("reset_val12", v12(), 12);
      checkOutput("reset_carry60", int'(c60), 0);

      applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(1, 1, 0, 0, 0, 0);
      checkOutput("first_inc60", v60(), 1);
      checkOutput("first_inc12", v12(), 1);
      checkOutput("wrap_carry12", int'(c12), 1);
      applyStimulus(1, 0, 0, 0, 0, 0);

      carries = 0;
      for (int k = 1; k < 60; k++) begin
         applyStimulus(1, 1, 0, 0, 0, 0);
         carries += int'(c60);
         applyStimulus(1, 0, 0, 0, 0, 0);
         carries += int'(c60);
      end
      checkOutput("wrap_val60", v60(), 0);
      checkOutput("carry_count60", carries, 1);

      applyStimulus(1, 0, 0, 1, 4, 5);
      checkOutput("load45_val60", v60(), 45);
      checkOutput("load45_err12", int'(e12), 1);
      applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 1, 6, 0);
      checkOutput("load60_val60", v60(), 45);
      checkOutput("load60_err60", int'(e60), 1);
      applyStimulus(1, 0, 0, 1, 0, 10);
      checkOutput("load0A_err60", int'(e60), 1);
      checkOutput("load0A_err12", int'(e12), 1);

      applyStimulus(1, 0, 0, 1, 0, 1);
      checkOutput("load01_val12", v12(), 1);
      applyStimulus(1, 0, 1, 0, 0, 0);
      checkOutput("dec_val12", v12(), 12);
      checkOutput("dec_borrow12", int'(b12), 1);
      checkOutput("dec_val60", v60(), 0);
      checkOutput("dec_borrow60", int'(b60), 0);
      applyStimulus(1, 0, 0, 0, 0, 0);

      for (int k = 0; k < 20; k++) applyStimulus(1, 1, 0, 0, 0, 0);
      checkOutput("held_inc_val60", v60(), 1);
      applyStimulus(1, 0, 0, 0, 0, 0);

      applyStimulus(1, 1, 1, 0, 0, 0);
      checkOutput("both_val60", v60(), 1);
      checkOutput("both_carry60", int'(c60), 0);
      checkOutput("both_borrow60", int'(b60), 0);
      applyStimulus(1, 0, 0, 0, 0, 0);

      applyStimulus(1, 1, 0, 1, 3, 7);
      checkOutput("load_inc_val60", v60(), 37);
      applyStimulus(1, 0, 0, 0, 0, 0);

      applyStimulus(0, 1, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) applyStimulus(1, 1, 0, 0, 0, 0);
      checkOutput("held_reset_val60", v60(), 0);
      applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(1, 1, 0, 0, 0, 0);
      checkOutput("after_reset_inc60", v60(), 1);
      applyStimulus(1, 0, 0, 0, 0, 0);

      applyStimulus(1, 0, 0, 1, 5, 9);
      checkOutput("load59_val60", v60(), 59);
      applyStimulus(0, 1, 0, 0, 0, 0);
      checkOutput("reset_over_inc60", v60(), 0);
      checkOutput("reset_no_carry60", int'(c60), 0);
      applyStimulus(1, 0, 0, 0, 0, 0);

      for (int k = 0; k < 3000; k++) begin
         applyStimulus(($urandom_range(0, 99) != 0),
                       ($urandom_range(0, 9) < 4),
                       ($urandom_range(0, 9) < 4),
                       ($urandom_range(0, 9) == 0),
                       int'($urandom_range(0, 11)),
                       int'($urandom_range(0, 11)));
      end

      applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0);
      c_load = 1'b1;
      applyStimulus(1, 0, 0, 0, 0, 0);
      c_load = 1'b0;
      checkOutput("chain_load_sec", int'(st) * 10 + int'(so), 59);
      checkOutput("chain_load_min", int'(mt) * 10 + int'(mo), 59);
      checkOutput("chain_load_hour", int'(ht) * 10 + int'(ho), 23);
      c_inc = 1'b1;
      applyStimulus(1, 0, 0, 0, 0, 0);
      c_inc = 1'b0;
      checkOutput("chain1_sec", int'(st) * 10 + int'(so), 0);
      checkOutput("chain1_sec_carry", int'(s_carry), 1);
      checkOutput("chain1_min", int'(mt) * 10 + int'(mo), 59);
      applyStimulus(1, 0, 0, 0, 0, 0);
      checkOutput("chain2_min", int'(mt) * 10 + int'(mo), 0);
      checkOutput("chain2_hour", int'(ht) * 10 + int'(ho), 23);
      checkOutput("chain2_sec_carry", int'(s_carry), 0);
      applyStimulus(1, 0, 0, 0, 0, 0);
      checkOutput("chain3_hour", int'(ht) * 10 + int'(ho), 0);
      checkOutput("chain3_hour_carry", int'(h_carry), 1);
      applyStimulus(1, 0, 0, 0, 0, 0);
      checkOutput("chain4_hour_carry", int'(h_carry), 0);

      check_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
